// File: rtl/fft_pkg.sv
// Shared FFT definitions: data widths, default frame geometry and the
// result-unloader state encoding.
package fft_pkg;
  localparam int FFT_WORD_W    = 32;
  localparam int FFT_HALF_W    = 16;
  localparam int FFT_N_POINTS  = 512;
  localparam int FFT_OUT_WORDS = 256;

  typedef enum logic [2:0] {IDLE, START, READ, DRAIN, DONE} unload_state_t;
endpackage

// File: rtl/fft_mag_approx.sv
// Alpha-max-beta-min magnitude of one {re, im} bin:
// max(|re|,|im|) + min(|re|,|im|)/2, saturated to 16 bits.
module fft_mag_approx
  import fft_pkg::*;
(
  input  logic [FFT_WORD_W-1:0] bin,
  output logic [FFT_HALF_W-1:0] m
);
  logic [FFT_HALF_W:0] re_x, im_x, re_abs, im_abs, mx, mn, sum;

  always_comb begin
    re_x = {bin[FFT_WORD_W-1], bin[FFT_WORD_W-1 -: FFT_HALF_W]};
    im_x = {bin[FFT_HALF_W-1], bin[FFT_HALF_W-1:0]};
    // 17-bit negate so that -32768 maps to +32768
    re_abs = re_x[FFT_HALF_W] ? (~re_x + 1'b1) : re_x;
    im_abs = im_x[FFT_HALF_W] ? (~im_x + 1'b1) : im_x;
    mx = (re_abs > im_abs) ? re_abs : im_abs;
    mn = (re_abs > im_abs) ? im_abs : re_abs;
    sum = mx + (mn >> 1);
    m = sum[FFT_HALF_W] ? '1 : sum[FFT_HALF_W-1:0];
  end
endmodule

// File: rtl/fft_result_unloader.sv
// Streams the first OUT_WORDS bins of a finished FFT frame out of the result
// RAM with start/done strobes. Define FFT_UNLOAD_MAG_EN for magnitude output.
module fft_result_unloader
  import fft_pkg::*;
#(
  parameter int N_POINTS  = FFT_N_POINTS,
  parameter int OUT_WORDS = FFT_OUT_WORDS,
  parameter int ADDR_W    = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fft_done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [FFT_WORD_W-1:0] rd_data,
  input  logic                  out_stall,
  output logic                  frame_start,
  output logic [FFT_WORD_W-1:0] out_word,
  output logic                  out_valid,
  output logic                  frame_done,
  output logic                  busy
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_WORDS - 1);

  unload_state_t state, state_nxt;
  logic armed;
  logic rd_pend;
  logic [FFT_WORD_W-1:0] word_nxt;

`ifdef FFT_UNLOAD_MAG_EN
  logic [FFT_HALF_W-1:0] mag;

  fft_mag_approx u_mag (
    .bin (rd_data),
    .m   (mag)
  );

  assign word_nxt = {mag, {FFT_HALF_W{1'b0}}};
`else
  assign word_nxt = rd_data;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      armed     <= 1'b1;
      rd_addr   <= '0;
      rd_pend   <= 1'b0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      // re-arm only while idle and the core reports no frame; leaving IDLE clears it
      if (state == IDLE) armed <= ~fft_done;
      if (state == START) rd_addr <= '0;
      else if (rd_en)     rd_addr <= rd_addr + 1'b1;
      rd_pend   <= rd_en;
      out_valid <= rd_pend;
      if (rd_pend) out_word <= word_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE:  if (fft_done && armed) state_nxt = START;
      START: begin
        frame_start = 1'b1;
        state_nxt   = READ;
      end
      READ: if (!out_stall) begin
        rd_en = 1'b1;
        if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
      end
      // the last word lands in out_word the cycle after its read returns
      DRAIN: if (!rd_pend) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fft_result_unloader.sv
// Bench for fft_result_unloader: scheduled stimulus, per-cycle expectations
// built from the frame timing rules, two instances (OUT_WORDS 256 and 1).
module tb_fft_result_unloader;
  localparam int NE = 8192;

  logic clk = 1'b0, reset = 1'b1, fft_done = 1'b0, fft_done1 = 1'b0, out_stall = 1'b0;
  logic rd_en0, rd_en1, fs0, fs1, vld0, vld1, fd0, fd1, busy0, busy1;
  logic [8:0] rd_addr0, rd_addr1;
  logic [31:0] rd_data0 = '0, rd_data1 = '0, out_word0, out_word1;
  logic [31:0] ram [512];

  bit sch_rst[NE], sch_done[NE], sch_done1[NE], sch_stall[NE];
  bit exp_fs[2][NE], exp_fd[2][NE], exp_vld[2][NE], exp_busy[2][NE], exp_rden[2][NE];
  logic [31:0] exp_word[2][NE];
  int exp_addr[2][NE];
  logic [31:0] last_word[2];
  int ed = 0, errors = 0, checks = 0;

  fft_result_unloader #(.N_POINTS(512), .OUT_WORDS(256)) u_dut0 (
    .clk(clk), .reset(reset), .fft_done(fft_done), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .out_stall(out_stall), .frame_start(fs0), .out_word(out_word0),
    .out_valid(vld0), .frame_done(fd0), .busy(busy0)
  );

  fft_result_unloader #(.N_POINTS(512), .OUT_WORDS(1)) u_dut1 (
    .clk(clk), .reset(reset), .fft_done(fft_done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .out_stall(out_stall), .frame_start(fs1), .out_word(out_word1),
    .out_valid(vld1), .frame_done(fd1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // result RAM with one cycle read latency
  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= ram[rd_addr0];
    if (rd_en1) rd_data1 <= ram[rd_addr1];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h want %0h", tag, ed, act, exp);
    end
  endtask

  function automatic logic [31:0] xform(input logic [31:0] w);
`ifdef FFT_UNLOAD_MAG_EN
    int re, im, a, b, m;
    re = int'($signed(w[31:16]));
    im = int'($signed(w[15:0]));
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    m = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
    if (m > 65535) m = 65535;
    return {m[15:0], 16'h0000};
`else
    return w;
`endif
  endfunction

  // Frame triggered at edge t: frame_start right after t, then one read per
  // non-stalled cycle, data two cycles after each read, done three after the last.
  task automatic plan_frame(input int d, input int t, input int ow, output int t_end);
    int e = t + 1;
    int issued = 0;
    int last = t + 1;
    exp_fs[d][t] = 1'b1;
    exp_busy[d][t] = 1'b1;
    while (issued < ow) begin
      exp_busy[d][e] = 1'b1;
      if (!sch_stall[e]) begin
        exp_rden[d][e] = 1'b1;
        exp_addr[d][e] = issued;
        exp_vld[d][e + 2] = 1'b1;
        exp_word[d][e + 2] = xform(ram[issued]);
        issued++;
        last = e;
      end
      e++;
    end
    for (int i = 1; i <= 3; i++) exp_busy[d][last + i] = 1'b1;
    exp_fd[d][last + 3] = 1'b1;
    t_end = last + 4;
  endtask

  task automatic truncate(input int r);
    for (int d = 0; d < 2; d++)
      for (int e = r; e < NE; e++) begin
        exp_fs[d][e] = 1'b0; exp_fd[d][e] = 1'b0; exp_vld[d][e] = 1'b0;
        exp_busy[d][e] = 1'b0; exp_rden[d][e] = 1'b0;
      end
  endtask

  task automatic check_dut(input int d, input logic fs, input logic fd, input logic vld,
                           input logic bsy, input logic rde, input logic [8:0] addr,
                           input logic [31:0] word);
    string p;
    p = $sformatf("d%0d.", d);
    chk({p, "frame_start"}, 32'(fs), 32'(exp_fs[d][ed]));
    chk({p, "frame_done"}, 32'(fd), 32'(exp_fd[d][ed]));
    chk({p, "out_valid"}, 32'(vld), 32'(exp_vld[d][ed]));
    chk({p, "busy"}, 32'(bsy), 32'(exp_busy[d][ed]));
    chk({p, "rd_en"}, 32'(rde), 32'(exp_rden[d][ed]));
    if (exp_rden[d][ed]) chk({p, "rd_addr"}, 32'(addr), exp_addr[d][ed]);
    if (exp_vld[d][ed]) last_word[d] = exp_word[d][ed];
    chk({p, "out_word"}, word, last_word[d]);
  endtask

  task automatic step();
    @(posedge clk);
    ed++;
    #1;
    reset = sch_rst[ed];
    fft_done = sch_done[ed];
    fft_done1 = sch_done1[ed];
    out_stall = sch_stall[ed];
    @(negedge clk);
    if (sch_rst[ed - 1]) begin
      last_word[0] = '0;
      last_word[1] = '0;
    end
    check_dut(0, fs0, fd0, vld0, busy0, rd_en0, rd_addr0, out_word0);
    check_dut(1, fs1, fd1, vld1, busy1, rd_en1, rd_addr1, out_word1);
  endtask

  task automatic run_until(input int e_end);
    while (ed < e_end) step();
  endtask

  initial begin
    int t, te;
    last_word[0] = '0;
    last_word[1] = '0;
    for (int i = 0; i < 512; i++) ram[i] = 32'(i);
    for (int e = 0; e < 3; e++) sch_rst[e] = 1'b1;

    // basic frame, RAM[i] = i, fft_done from edge 9 sampled at 10
    for (int e = 9; e < 13; e++) sch_done[e] = 1'b1;
    plan_frame(0, 10, 256, te);
    run_until(te + 5);

    for (int i = 0; i < 512; i++) ram[i] = $urandom;
`ifdef FFT_UNLOAD_MAG_EN
    ram[0] = 32'h0BB8_F060;
    ram[1] = 32'h8000_8000;
`endif

    // ten-cycle stall burst inside READ
    t = ed + 5;
    for (int e = t - 1; e < t + 3; e++) sch_done[e] = 1'b1;
    for (int e = t + 40; e < t + 50; e++) sch_stall[e] = 1'b1;
    plan_frame(0, t, 256, te);
    run_until(te + 3);

    // random stall patterns
    for (int k = 0; k < 2; k++) begin
      t = ed + 5;
      sch_done[t - 1] = 1'b1;
      for (int e = t; e < t + 500; e++) sch_stall[e] = ($urandom_range(0, 3) == 0);
      plan_frame(0, t, 256, te);
      run_until(te + 3);
    end

    // level-held fft_done: one frame, then a one-cycle drop re-arms
    t = ed + 600;
    for (int e = t - 1; e < t + 999; e++) sch_done[e] = 1'b1;
    for (int e = t + 1000; e < t + 1003; e++) sch_done[e] = 1'b1;
    plan_frame(0, t, 256, te);
    plan_frame(0, t + 1001, 256, te);
    run_until(te + 3);

    // reset right after word 100, then restart from address 0
    t = ed + 5;
    sch_done[t - 1] = 1'b1;
    plan_frame(0, t, 256, te);
    sch_rst[t + 103] = 1'b1;
    truncate(t + 104);
    sch_done[t + 109] = 1'b1;
    plan_frame(0, t + 110, 256, te);
    run_until(te + 3);

    // single-word frames, plain and with a stall right at READ entry
    t = ed + 5;
    sch_done1[t - 1] = 1'b1;
    plan_frame(1, t, 1, te);
    run_until(te + 3);
    t = ed + 5;
    sch_done1[t - 1] = 1'b1;
    sch_stall[t + 1] = 1'b1;
    sch_stall[t + 2] = 1'b1;
    plan_frame(1, t, 1, te);
    run_until(te + 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
